// File: rtl/cntr8_pkg.sv
// Shared definitions for the 8-bit counter and its command generator.
// Op codes and FSM state encodings.
package cntr8_pkg;

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_INC  = 2'b01,
    OP_DEC  = 2'b10,
    OP_HOLD = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/cmd_ns_logic.sv
// Next-state and remaining-count logic for the counter command generator.
// The effective run length is computed here on acceptance.
import cntr8_pkg::*;

module cmd_ns_logic #(
  parameter int LEN_W = 4
) (
  input  state_e           state_q,
  input  logic             cmd_valid,
  input  logic [1:0]       cmd_op,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic [LEN_W:0]   rem_q,
  output state_e           state_d,
  output logic [LEN_W:0]   rem_d
);

  logic [LEN_W:0] eff_len;

  always_comb begin
    eff_len = {1'b0, cmd_len};
    if (cmd_op == OP_LOAD)
      eff_len = (LEN_W+1)'(1);
    else if (cmd_len == '0)
      eff_len = {1'b1, {LEN_W{1'b0}}};
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          state_d = ST_RUN;
          rem_d   = eff_len;
        end
      end
      ST_RUN: begin
        rem_d = rem_q - (LEN_W+1)'(1);
        if (rem_q == (LEN_W+1)'(1))
          state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: rtl/cntr8_cmd_gen.sv
// Command generator driving an 8-bit up/down/load counter,
// with a shadow model of the counter value.
import cntr8_pkg::*;

module cntr8_cmd_gen #(
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [7:0]       cmd_data,
  input  logic [LEN_W-1:0] cmd_len,
  output logic             load,
  output logic             inc,
  output logic [7:0]       d_in,
  output logic [7:0]       exp_cnt,
  output logic             busy,
  output logic             done
);

  state_e         state_q, state_d;
  op_e            op_q, op_d;
  logic [7:0]     data_q, data_d;
  logic [7:0]     cnt_q, cnt_d;
  logic [LEN_W:0] rem_q, rem_d;
  logic           hs;

  assign cmd_ready = (state_q == ST_IDLE);
  assign hs        = cmd_valid & cmd_ready;
  assign exp_cnt   = cnt_q;
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);

  cmd_ns_logic #(.LEN_W(LEN_W)) u_ns (
    .state_q  (state_q),
    .cmd_valid(cmd_valid),
    .cmd_op   (cmd_op),
    .cmd_len  (cmd_len),
    .rem_q    (rem_q),
    .state_d  (state_d),
    .rem_d    (rem_d)
  );

  always_comb begin
    op_d   = op_q;
    data_d = data_q;
    if (hs) begin
      op_d   = op_e'(cmd_op);
      data_d = cmd_data;
    end
  end

  // The counter cannot hold, so idle cycles reload its own value.
  always_comb begin
    load = 1'b1;
    inc  = 1'b0;
    d_in = cnt_q;
    if (state_q == ST_RUN) begin
      unique case (op_q)
        OP_LOAD: d_in = data_q;
        OP_INC: begin
          load = 1'b0;
          inc  = 1'b1;
        end
        OP_DEC:  load = 1'b0;
        default: d_in = cnt_q;
      endcase
    end
  end

  always_comb begin
    if (load)
      cnt_d = d_in;
    else if (inc)
      cnt_d = cnt_q + 8'd1;
    else
      cnt_d = cnt_q - 8'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      op_q    <= OP_HOLD;
      data_q  <= 8'h00;
      cnt_q   <= 8'h00;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
    end
  end

endmodule

// File: tb/tb_cntr8_cmd_gen.sv
// Self-checking bench for cntr8_cmd_gen: directed scenarios plus
// random command streams against a command-level reference model.
module tb_cntr8_cmd_gen;

  localparam int LEN_W = 4;
  localparam logic [1:0] OP_L = 2'b00;
  localparam logic [1:0] OP_I = 2'b01;
  localparam logic [1:0] OP_D = 2'b10;
  localparam logic [1:0] OP_H = 2'b11;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [1:0]       cmd_op = 2'b00;
  logic [7:0]       cmd_data = 8'h00;
  logic [LEN_W-1:0] cmd_len = '0;
  logic             load, inc, busy, done;
  logic [7:0]       d_in, exp_cnt;

  int checks = 0;
  int failures = 0;
  int m_cnt = 0;

  always #5 clk = ~clk;

  cntr8_cmd_gen #(.LEN_W(LEN_W)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op   (cmd_op),
    .cmd_data (cmd_data),
    .cmd_len  (cmd_len),
    .load     (load),
    .inc      (inc),
    .d_in     (d_in),
    .exp_cnt  (exp_cnt),
    .busy     (busy),
    .done     (done)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issue one command and follow it cycle by cycle to IDLE.
  task automatic run_cmd(input logic [1:0] op, input logic [7:0] data,
                         input logic [LEN_W-1:0] len,
                         input bit hold, input bit scramble);
    int eff, busy_n, w, lat;
    logic el, ei;
    logic [7:0] ed;
    w = 0;
    while (!cmd_ready && w < 40) begin
      tick;
      w++;
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL ready_timeout: cmd_ready=%b required 1", cmd_ready);
    end
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    cmd_len   = len;
    tick;
    lat = 1;
    eff = (op == OP_L) ? 1 : ((len == 0) ? (1 << LEN_W) : int'(len));
    if (!hold) cmd_valid = 1'b0;
    if (scramble) begin
      cmd_op   = ~op;
      cmd_data = ~data;
      cmd_len  = LEN_W'($urandom);
    end
    busy_n = 0;
    for (int i = 0; i < eff; i++) begin
      el = (op == OP_L) || (op == OP_H);
      ei = (op == OP_I);
      ed = (op == OP_L) ? data : m_cnt[7:0];
      checks++;
      if ({busy, done, cmd_ready, load, inc} !== {1'b1, 1'b0, 1'b0, el, ei}
          || d_in !== ed) begin
        failures++;
        $display("FAIL run_outputs op=%0d cyc=%0d: busy=%b done=%b rdy=%b load=%b inc=%b d_in=%h required 1 0 0 %b %b %h",
                 op, i, busy, done, cmd_ready, load, inc, d_in, el, ei, ed);
      end
      busy_n += int'(busy);
      tick;
      lat++;
      case (op)
        OP_L: m_cnt = int'(data);
        OP_I: m_cnt = (m_cnt + 1) % 256;
        OP_D: m_cnt = (m_cnt + 255) % 256;
        default: ;
      endcase
      checks++;
      if (exp_cnt !== m_cnt[7:0]) begin
        failures++;
        $display("FAIL exp_cnt op=%0d cyc=%0d: got %h required %h",
                 op, i, exp_cnt, m_cnt[7:0]);
      end
    end
    checks++;
    if ({busy, done, cmd_ready, load, inc} !== 5'b11010
        || d_in !== m_cnt[7:0] || lat != eff + 1) begin
      failures++;
      $display("FAIL done_state: busy=%b done=%b rdy=%b load=%b inc=%b d_in=%h lat=%0d required 1 1 0 1 0 %h lat=%0d",
               busy, done, cmd_ready, load, inc, d_in, lat,
               m_cnt[7:0], eff + 1);
    end
    busy_n += int'(busy);
    tick;
    checks++;
    if ({busy, done, cmd_ready} !== 3'b001 || exp_cnt !== m_cnt[7:0]
        || busy_n != eff + 1) begin
      failures++;
      $display("FAIL idle_after: busy=%b done=%b rdy=%b cnt=%h busy_cycles=%0d required 0 0 1 %h %0d",
               busy, done, cmd_ready, exp_cnt, busy_n, m_cnt[7:0], eff + 1);
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    #3;
    checks++;
    if ({load, inc, cmd_ready, busy, done} !== 5'b10100
        || d_in !== 8'h00 || exp_cnt !== 8'h00) begin
      failures++;
      $display("FAIL reset_active: load=%b inc=%b rdy=%b busy=%b done=%b d_in=%h cnt=%h required 1 0 1 0 0 00 00",
               load, inc, cmd_ready, busy, done, d_in, exp_cnt);
    end
    tick;
    tick;
    reset_n = 1'b1;
    m_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      tick;
      checks++;
      if ({load, inc, cmd_ready, busy, done} !== 5'b10100
          || d_in !== 8'h00 || exp_cnt !== 8'h00) begin
        failures++;
        $display("FAIL reset_idle cyc=%0d: load=%b inc=%b rdy=%b busy=%b done=%b d_in=%h cnt=%h required 1 0 1 0 0 00 00",
                 i, load, inc, cmd_ready, busy, done, d_in, exp_cnt);
      end
    end
  endtask

  task automatic test_load_inc;
    run_cmd(OP_L, 8'hFE, LEN_W'($urandom), 1'b0, 1'b0);
    run_cmd(OP_I, 8'h00, LEN_W'(3), 1'b0, 1'b0);
    checks++;
    if (exp_cnt !== 8'h01) begin
      failures++;
      $display("FAIL load_inc_end: got %h required 01", exp_cnt);
    end
  endtask

  task automatic test_dec_wrap;
    run_cmd(OP_D, 8'($urandom), LEN_W'(0), 1'b0, 1'b0);
    checks++;
    if (exp_cnt !== 8'hF1) begin
      failures++;
      $display("FAIL dec_wrap_end: got %h required f1", exp_cnt);
    end
  endtask

  task automatic test_hold_valid;
    run_cmd(OP_L, 8'h42, LEN_W'(0), 1'b0, 1'b0);
    run_cmd(OP_H, 8'h00, LEN_W'(5), 1'b1, 1'b0);
    run_cmd(OP_H, 8'h00, LEN_W'(5), 1'b0, 1'b0);
    checks++;
    if (exp_cnt !== 8'h42) begin
      failures++;
      $display("FAIL hold_end: got %h required 42", exp_cnt);
    end
  endtask

  task automatic test_cmd_change;
    run_cmd(OP_L, 8'($urandom), LEN_W'(1), 1'b0, 1'b1);
    run_cmd(OP_I, 8'($urandom), LEN_W'($urandom_range(2, 9)), 1'b0, 1'b1);
    run_cmd(OP_D, 8'($urandom), LEN_W'($urandom_range(2, 9)), 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid;
    run_cmd(OP_L, 8'h5A, LEN_W'(0), 1'b0, 1'b0);
    cmd_valid = 1'b1;
    cmd_op    = OP_I;
    cmd_len   = LEN_W'(8);
    tick;
    cmd_valid = 1'b0;
    tick;
    reset_n = 1'b0;
    #1;
    m_cnt = 0;
    checks++;
    if ({busy, done, cmd_ready, load, inc} !== 5'b00110
        || exp_cnt !== 8'h00 || d_in !== 8'h00) begin
      failures++;
      $display("FAIL reset_mid: busy=%b done=%b rdy=%b load=%b inc=%b cnt=%h d_in=%h required 0 0 1 1 0 00 00",
               busy, done, cmd_ready, load, inc, exp_cnt, d_in);
    end
    tick;
    reset_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick;
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || exp_cnt !== 8'h00) begin
        failures++;
        $display("FAIL reset_mid_after cyc=%0d: done=%b busy=%b cnt=%h required 0 0 00",
                 i, done, busy, exp_cnt);
      end
    end
  endtask

  task automatic test_random;
    int gap;
    for (int n = 0; n < 30; n++) begin
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        tick;
        checks++;
        if (exp_cnt !== m_cnt[7:0] || load !== 1'b1 || d_in !== m_cnt[7:0]) begin
          failures++;
          $display("FAIL random_gap: cnt=%h load=%b d_in=%h required %h 1 %h",
                   exp_cnt, load, d_in, m_cnt[7:0], m_cnt[7:0]);
        end
      end
      run_cmd(2'($urandom_range(0, 3)), 8'($urandom), LEN_W'($urandom),
              1'b0, 1'($urandom));
    end
  endtask

  initial begin
    test_reset;
    test_load_inc;
    test_dec_wrap;
    test_hold_valid;
    test_cmd_change;
    test_reset_mid;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cntr8_cmd_gen.md
CNTR8_CMD_GEN -- requirements
Module: cntr8_cmd_gen

Interface
REQ-001 Parameter LEN_W, default 4, width of the repeat-length field.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset_n  input  1  asynchronous active-low reset.
REQ-004 cmd_valid  input  1  command offered.
REQ-005 cmd_ready  output  1  generator can accept a command.
REQ-006 cmd_op  input  2  00 LOAD, 01 INC, 10 DEC, 11 HOLD.
REQ-007 cmd_data  input  8  load value; used only for op LOAD.
REQ-008 cmd_len  input  LEN_W  cycle count for INC/DEC/HOLD; 0 encodes 2^LEN_W.
REQ-009 load  output  1  counter load strobe.
REQ-010 inc  output  1  counter increment select; load=0, inc=0 means decrement.
REQ-011 d_in  output  8  counter load data.
REQ-012 exp_cnt  output  8  modelled counter value after the current edge.
REQ-013 busy  output  1  high whenever state is not IDLE.
REQ-014 done  output  1  one-cycle pulse at command completion.

Function
REQ-015 The FSM SHALL have states IDLE, RUN and DONE only.
REQ-016 The counter has no hold encoding, so in IDLE and DONE the block SHALL drive load=1, inc=0, d_in=exp_cnt.
REQ-017 In RUN the block SHALL drive: LOAD -> load=1, d_in=data_r; INC -> load=0, inc=1; DEC -> load=0, inc=0; HOLD -> load=1, d_in=exp_cnt.
REQ-018 In RUN with op INC or DEC, d_in SHALL equal exp_cnt (don't-care to the counter, fixed for determinism).
REQ-019 load, inc and d_in SHALL be combinational decodes of state, op_r, data_r and exp_cnt.
REQ-020 cmd_ready SHALL be 1 exactly when the state is IDLE.
REQ-021 A handshake (cmd_valid and cmd_ready at an edge) SHALL latch cmd_op, cmd_data and the effective length, and move IDLE -> RUN.
REQ-022 The effective length SHALL be 1 for LOAD regardless of cmd_len, and cmd_len otherwise, with 0 mapped to 2^LEN_W.
REQ-023 RUN SHALL last exactly the effective length in cycles, decrementing a remaining counter each cycle, then move to DONE.
REQ-024 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-025 The latency from handshake edge to the done pulse SHALL be effective length + 1 cycles.
REQ-026 A command can be accepted at the earliest 2 cycles after done.
REQ-027 exp_cnt SHALL update every edge from the driven outputs: load -> d_in; inc -> exp_cnt+1; otherwise exp_cnt-1, modulo 256.
REQ-028 exp_cnt SHALL wrap 8'hFF+1 -> 8'h00 and 8'h00-1 -> 8'hFF silently.
REQ-029 cmd_valid outside IDLE SHALL be ignored; no command is queued.
REQ-030 cmd_* SHALL be sampled only on the handshake edge; later changes SHALL have no effect.

Reset
REQ-031 reset_n low SHALL force state=IDLE, exp_cnt=0, op_r=HOLD, data_r=0 and remaining=0, asynchronously.
REQ-032 During and right after reset the outputs SHALL be load=1, inc=0, d_in=0, cmd_ready=1, busy=0, done=0.
REQ-033 Reset asserted mid-RUN SHALL abandon the command with no done pulse.

Structure
REQ-034 Op codes (LOAD/INC/DEC/HOLD) and state encodings SHALL live in the shared cntr8 definitions package, used by this block and the counter.
REQ-035 Next-state logic SHALL be a separate sub-module, cmd_ns_logic; registers and output decode stay in cntr8_cmd_gen.

Verification
REQ-036 Reset, then idle 5 cycles -> load=1, d_in=0, exp_cnt stays 0, cmd_ready=1.
REQ-037 LOAD data=8'hFE, then INC len=3 -> exp_cnt goes FE, FF, 00, 01; done pulses 2 cycles after the LOAD handshake and 4 cycles after the INC handshake.
REQ-038 From exp_cnt=8'h01, DEC len=0 (16 cycles) -> exp_cnt ends at 8'hF1; busy=1 for 17 cycles.
REQ-039 HOLD len=5 from 8'h42, with cmd_valid held high throughout -> exp_cnt constant at 42; the second command is accepted only in IDLE after DONE.
REQ-040 Reset asserted on the 2nd cycle of INC len=8 -> immediate IDLE, exp_cnt=0, no done pulse.
REQ-041 Change cmd_data/cmd_op the cycle after the handshake -> the latched command runs unchanged.
